// File: rtl/lsu_mem_if.sv
// Load/store unit: turns one core load/store into a single handshaked bus transaction,
// stalls the core until it completes, and returns lane-selected, extended load data.
module lsu_mem_if #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The counter value seen in the last permitted REQ/RESP cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    logic        f3_ok_s, align_ok_s, valid_s, last_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = d;
        endcase
    endfunction

    // Access legality and lane mapping of the instruction currently on the core ports.
    always_comb begin
        f3_ok_s    = 1'b0;
        align_ok_s = 1'b0;
        be_s       = 4'b1111;
        wdata_s    = WriteData;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
            3'b100, 3'b101:         f3_ok_s = MemRead & ~MemWrite;
            default:                f3_ok_s = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00: begin
                align_ok_s = 1'b1;
                be_s       = 4'b0001 << ALUResult[1:0];
                wdata_s    = {4{WriteData[7:0]}};
            end
            2'b01: begin
                align_ok_s = ~ALUResult[0];
                be_s       = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{WriteData[15:0]}};
            end
            2'b10: begin
                align_ok_s = (ALUResult[1:0] == 2'b00);
                be_s       = 4'b1111;
                wdata_s    = WriteData;
            end
            default: begin
                align_ok_s = 1'b0;
                be_s       = 4'b1111;
                wdata_s    = WriteData;
            end
        endcase
    end

    assign valid_s = (MemRead ^ MemWrite) & f3_ok_s & align_ok_s;
    assign last_s  = (cnt_q == TMO_LAST);

    // Next-state and datapath update; a load granted in its final allowed cycle aborts
    // because its data could never arrive inside the window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        off_d   = off_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = 8'd0;
                fault_d = 1'b0;
                if (valid_s) begin
                    addr_d  = ALUResult[31:2];
                    off_d   = ALUResult[1:0];
                    we_d    = MemWrite;
                    be_d    = be_s;
                    wdata_d = wdata_s;
                    f3_d    = funct3;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_gnt && we_q) begin
                    state_d = S_DONE;
                end else if (mem_gnt && !last_s) begin
                    state_d = S_RESP;
                end else if (last_s) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    rdata_d = load_ext(mem_rdata, off_q, f3_q);
                    state_d = S_DONE;
                end else if (last_s) begin
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_DONE: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 30'd0;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // Core handshake; the IDLE terms react in the same cycle the instruction is presented.
    always_comb begin
        Stall    = 1'b0;
        MemFault = 1'b0;
        case (state_q)
            S_IDLE: begin
                Stall    = valid_s;
                MemFault = (MemRead | MemWrite) & ~valid_s;
            end
            S_REQ, S_RESP: begin
                Stall    = 1'b1;
                MemFault = 1'b0;
            end
            S_DONE: begin
                Stall    = 1'b0;
                MemFault = fault_q;
            end
            default: begin
                Stall    = 1'b0;
                MemFault = 1'b0;
            end
        endcase
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign ReadData  = rdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Randomised scoreboard bench for lsu_mem_if: a core driver pushes expected outcomes,
// a bus responder checks request fields, and a monitor compares each completion.
module tb_lsu_mem_if;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] ALUResult = 32'd0, WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Stall, MemFault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    lsu_mem_if #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .MemFault(MemFault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [31:0] rd;
        int          stall;
        int          req;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0, n_fail = 0;
    logic [31:0] rd_model = 32'd0;

    // Bus-side expectations and responder behaviour for the current transaction.
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0, rd_val = 32'd0;
    logic [3:0]  exp_be = 4'd0;
    logic        exp_we = 1'b0;
    int          g_delay = 0, r_delay = 0;
    int          req_cnt = 0, rv_cnt = 0, req_total = 0, acc_total = 0;
    logic        resp_phase = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (8 * int'(off));
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b100:  return sh & 32'h0000_00FF;
            3'b001:  return 32'($signed(sh[15:0]));
            3'b101:  return sh & 32'h0000_FFFF;
            default: return sh;
        endcase
    endfunction

    // Bus responder: grants after g_delay request cycles, returns data r_delay cycles later,
    // and throws stray gnt/rvalid pulses whenever the DUT must ignore them.
    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (mem_req) begin
            req_total++;
            check("req_addr", mem_addr, exp_addr);
            check("req_we", 32'(mem_we), 32'(exp_we));
            check("req_be", 32'(mem_be), 32'(exp_be));
            if (exp_we) check("req_wdata", mem_wdata, exp_wdata);
            if (req_cnt == g_delay) begin
                mem_gnt = 1'b1;
                acc_total++;
                if (!mem_we) begin
                    resp_phase = 1'b1;
                    rv_cnt     = 0;
                end
            end
            req_cnt++;
        end else begin
            req_cnt = 0;
            if (resp_phase) begin
                if (rv_cnt == r_delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_val;
                    resp_phase = 1'b0;
                end else begin
                    rv_cnt++;
                end
            end else begin
                mem_gnt    = ($urandom_range(0, 3) == 0);
                mem_rvalid = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: a completion is the first Stall-low cycle after a stall, or an immediate fault.
    logic prev_stall = 1'b0;
    int   stall_run = 0, req_base = 0, acc_base = 0;
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        if (!reset) begin
            prev_stall = 1'b0;
            stall_run  = 0;
            req_base   = req_total;
            acc_base   = acc_total;
        end else begin
            if (Stall) stall_run++;
            ev = prev_stall ? !Stall : MemFault;
            if (ev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got fault=%0b rd=%h, expected none",
                             MemFault, ReadData);
                end else begin
                    e = exp_q.pop_front();
                    check("fault", 32'(MemFault), 32'(e.fault));
                    check("readdata", ReadData, e.rd);
                    check("stall_cycles", 32'(stall_run), 32'(e.stall));
                    check("req_cycles", 32'(req_total - req_base), 32'(e.req));
                    check("req_accepts", 32'(acc_total - acc_base), 32'(e.acc));
                end
                stall_run = 0;
                req_base  = req_total;
                acc_base  = acc_total;
            end
            prev_stall = Stall;
        end
    end

    task automatic wait_resp_idle();
        for (int i = 0; i < 30; i++) begin
            if (!resp_phase) break;
            @(negedge clk);
        end
        check("resp_idle_bound", 32'(resp_phase), 32'd0);
    endtask

    task automatic set_bus_exp(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd);
        logic [1:0] off;
        off       = addr[1:0];
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_we    = wr;
        exp_be    = (f3[1:0] == 2'd0) ? 4'(1 << off) : (f3[1:0] == 2'd1) ? 4'(3 << off) : 4'hF;
        exp_wdata = (f3[1:0] == 2'd0) ? 32'(wd[7:0]) * 32'h0101_0101 :
                    (f3[1:0] == 2'd1) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int g, input int r, input logic [31:0] rdv);
        logic legal, aligned, valid, ok, st, done;
        int   size;
        exp_t e;
        legal   = (rd && !wr) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                              : (f3 inside {3'd0, 3'd1, 3'd2});
        size    = 1 << f3[1:0];
        aligned = ((addr % 32'(size)) == 32'd0);
        valid   = (rd ^ wr) && legal && aligned;
        ok      = valid && (wr ? (g + 1 <= T) : (g + r + 2 <= T));
        if (valid && rd) rd_model = ok ? ref_load(f3, addr[1:0], rdv) : 32'd0;
        e.fault = !ok;
        e.rd    = rd_model;
        e.stall = !valid ? 0 : ok ? (wr ? g + 2 : g + r + 3) : T + 1;
        e.req   = !valid ? 0 : (g + 1 < T) ? g + 1 : T;
        e.acc   = (valid && g < T) ? 1 : 0;
        wait_resp_idle();
        set_bus_exp(wr, f3, addr, wd);
        g_delay = g;
        r_delay = r;
        rd_val  = rdv;
        if (rd || wr) exp_q.push_back(e);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            st = Stall;
            @(posedge clk); #1;
            if (!st) begin
                done = 1'b1;
                break;
            end
        end
        check("stall_release_bound", 32'(done), 32'd1);
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        logic [2:0] legal_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic       rd, wr;
        logic [2:0] f3;
        logic [31:0] a;
        int         x;

        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", ReadData, 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_fault", 32'(MemFault), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b1;

        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 32'd0);
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h8012_3456);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1, 0, 32'h8012_3456);
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, 1, 32'h8001_5678);
        do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 0, 0, 32'h8001_5678);
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 0, 0, 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 0, 32'd0);
        do_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h1234, 0, 0, 32'd0);
        do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 0, 0, 32'd0);
        do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 0, 0, 32'd0);
        do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 0, 0, 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 10, 0, 32'h1234_5678);
        do_access(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 0, 0, 32'h5555_AAAA);

        // Reset while a load waits for its data; the late rvalid must be ignored.
        wait_resp_idle();
        set_bus_exp(1'b0, 3'b010, 32'h200, 32'd0);
        g_delay = 0; r_delay = 3; rd_val = 32'hCAFE_F00D;
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        MemRead = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_stall", 32'(Stall), 32'd0);
        check("rst_mid_readdata", ReadData, 32'd0);
        rd_model = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_resp_idle();
        @(negedge clk);
        check("post_rst_readdata", ReadData, 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 0, 0, 32'h0BAD_F00D);

        for (int n = 0; n < 250; n++) begin
            x  = $urandom_range(0, 15);
            rd = (x < 7) || (x >= 14);
            wr = (x >= 7);
            f3 = ($urandom_range(0, 9) < 9) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
            do_access(rd, wr, f3, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                      $urandom);
        end

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
